// File: rtl/std_seq_checker.sv
// ----------------------------------------------------------------------------
// std_seq_checker
//
// Receive-side checker for the 3-bit generator code sequence
//   000, 011, 010, 101, 001, 110, 100, 111, (wraps)
//
// The checker acquires lock on the incoming stream and then tracks the
// expected next code. It flags and counts sequence errors, and it drops lock
// after repeated misses.
//
// Ports:
//   clk        in   1      clock, rising edge
//   rst        in   1      asynchronous reset, active-low
//   seq_in     in   3      code from the generator
//   seq_valid  in   1      seq_in is sampled only when this is 1
//   locked     out  1      1 while in the locked state
//   index      out  3      sequence position (0..7) of the last valid sample
//   err        out  1      one-cycle pulse on a mismatch while locked
//   err_cnt    out  ERR_W  saturating count of err pulses
//   frame_done out  1      (STD_CHK_FRAME_EN only) one-cycle pulse when a
//                          locked, in-order 111 sample closes a frame
//
// Build option:
//   STD_CHK_FRAME_EN  adds the frame_done output and the logic behind it.
//
// Parameters:
//   LOCK_CNT    consecutive in-order samples needed to lock (2..15)
//   UNLOCK_CNT  consecutive misses while locked that drop lock (1..15)
//   ERR_W       width of the saturating error counter
// ----------------------------------------------------------------------------
module std_seq_checker #(
    parameter int unsigned LOCK_CNT   = 4,
    parameter int unsigned UNLOCK_CNT = 2,
    parameter int unsigned ERR_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       seq_in,
    input  logic             seq_valid,
    output logic             locked,
    output logic [2:0]       index,
    output logic             err,
`ifdef STD_CHK_FRAME_EN
    output logic [ERR_W-1:0] err_cnt,
    output logic             frame_done
`else
    output logic [ERR_W-1:0] err_cnt
`endif
);

    localparam logic [3:0] LockCnt   = LOCK_CNT[3:0];
    localparam logic [3:0] UnlockCnt = UNLOCK_CNT[3:0];

    typedef enum logic [1:0] {StHunt, StVerify, StLocked} state_e;

    state_e     state;
    logic [3:0] ok_cnt;
    logic [3:0] miss_cnt;
    logic [2:0] exp_pos;

    logic [2:0] pos;
    logic       match;
    logic [3:0] ok_inc;
    logic [3:0] miss_inc;

    // Code -> sequence position. All eight codes are legal.
    function automatic logic [2:0] code_to_pos(input logic [2:0] code);
        logic [2:0] p;
        unique case (code)
            3'b000:  p = 3'd0;
            3'b011:  p = 3'd1;
            3'b010:  p = 3'd2;
            3'b101:  p = 3'd3;
            3'b001:  p = 3'd4;
            3'b110:  p = 3'd5;
            3'b100:  p = 3'd6;
            default: p = 3'd7;  // 3'b111
        endcase
        return p;
    endfunction

    always_comb begin
        pos      = code_to_pos(seq_in);
        match    = (pos == exp_pos);
        ok_inc   = ok_cnt + 4'd1;
        miss_inc = miss_cnt + 4'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= StHunt;
            locked   <= 1'b0;
            index    <= 3'd0;
            err      <= 1'b0;
            err_cnt  <= '0;
            ok_cnt   <= 4'd0;
            miss_cnt <= 4'd0;
            exp_pos  <= 3'd0;
`ifdef STD_CHK_FRAME_EN
            frame_done <= 1'b0;
`endif
        end else begin
            // Pulses default low; they only rise on a valid sample.
            err <= 1'b0;
`ifdef STD_CHK_FRAME_EN
            frame_done <= 1'b0;
`endif
            if (seq_valid) begin
                index <= pos;
                case (state)
                    StHunt: begin
                        state   <= StVerify;
                        ok_cnt  <= 4'd1;
                        exp_pos <= pos + 3'd1;
                    end
                    StVerify: begin
                        if (match) begin
                            ok_cnt  <= ok_inc;
                            exp_pos <= exp_pos + 3'd1;
                            if (ok_inc == LockCnt) begin
                                state    <= StLocked;
                                locked   <= 1'b1;
                                miss_cnt <= 4'd0;
                            end
                        end else begin
                            // Resync onto the received code; no error while verifying.
                            ok_cnt  <= 4'd1;
                            exp_pos <= pos + 3'd1;
                        end
                    end
                    StLocked: begin
                        // Flywheel: expectation advances regardless of what arrived.
                        exp_pos <= exp_pos + 3'd1;
                        if (match) begin
                            miss_cnt <= 4'd0;
`ifdef STD_CHK_FRAME_EN
                            frame_done <= (pos == 3'd7);
`endif
                        end else begin
                            err      <= 1'b1;
                            miss_cnt <= miss_inc;
                            if (err_cnt != '1) begin
                                err_cnt <= err_cnt + ERR_W'(1);
                            end
                            if (miss_inc == UnlockCnt) begin
                                state    <= StHunt;
                                locked   <= 1'b0;
                                ok_cnt   <= 4'd0;
                                miss_cnt <= 4'd0;
                            end
                        end
                    end
                    default: begin
                        state  <= StHunt;
                        locked <= 1'b0;
                        ok_cnt <= 4'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_std_seq_checker.sv
// ----------------------------------------------------------------------------
// tb_std_seq_checker
//
// Self-checking bench for std_seq_checker. A behavioural reference model
// (position lookup by table search, integer counters) predicts every output
// after each clock edge; directed scenarios are followed by a long random run.
// ----------------------------------------------------------------------------
module tb_std_seq_checker;

    localparam int ERR_W    = 8;
    localparam int LOCK_N   = 4;
    localparam int UNLOCK_N = 2;
    localparam int ERR_MAX  = (1 << ERR_W) - 1;

    logic             clk;
    logic             rst;
    logic [2:0]       seq_in;
    logic             seq_valid;
    logic             locked;
    logic [2:0]       index;
    logic             err;
    logic [ERR_W-1:0] err_cnt;
    logic             frame_done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [2:0] seq_codes [8] = '{3'b000, 3'b011, 3'b010, 3'b101,
                                  3'b001, 3'b110, 3'b100, 3'b111};

    std_seq_checker #(
        .LOCK_CNT   (LOCK_N),
        .UNLOCK_CNT (UNLOCK_N),
        .ERR_W      (ERR_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .seq_in     (seq_in),
        .seq_valid  (seq_valid),
        .locked     (locked),
        .index      (index),
        .err        (err),
`ifdef STD_CHK_FRAME_EN
        .err_cnt    (err_cnt),
        .frame_done (frame_done)
`else
        .err_cnt    (err_cnt)
`endif
    );

`ifndef STD_CHK_FRAME_EN
    assign frame_done = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int m_mode;     // 0 hunting, 1 verifying, 2 locked
    int m_ok;
    int m_miss;
    int m_exp;
    int m_index;
    int m_errcnt;
    bit m_err;
    bit m_frame;
    int n_frames;

    function automatic int pos_of(input logic [2:0] c);
        for (int i = 0; i < 8; i++) begin
            if (seq_codes[i] == c) return i;
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_ok = 0; m_miss = 0; m_exp = 0;
        m_index = 0; m_errcnt = 0; m_err = 0; m_frame = 0;
    endtask

    task automatic model_step(input logic v, input logic [2:0] c);
        int p;
        m_err   = 0;
        m_frame = 0;
        if (!v) return;
        p = pos_of(c);
        m_index = p;
        if (m_mode == 0) begin
            m_mode = 1;
            m_ok   = 1;
            m_exp  = (p + 1) % 8;
        end else if (m_mode == 1) begin
            if (p == m_exp) begin
                m_ok  = m_ok + 1;
                m_exp = (m_exp + 1) % 8;
                if (m_ok == LOCK_N) begin
                    m_mode = 2;
                    m_miss = 0;
                end
            end else begin
                m_ok  = 1;
                m_exp = (p + 1) % 8;
            end
        end else begin
            if (p == m_exp) begin
                m_miss  = 0;
                m_frame = (p == 7);
            end else begin
                m_err    = 1;
                m_errcnt = (m_errcnt < ERR_MAX) ? m_errcnt + 1 : ERR_MAX;
                m_miss   = m_miss + 1;
                if (m_miss == UNLOCK_N) begin
                    m_mode = 0;
                    m_ok   = 0;
                    m_miss = 0;
                end
            end
            m_exp = (m_exp + 1) % 8;
        end
    endtask

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, want, $time);
        end
    endtask

    task automatic check_all();
        check_eq("locked", {31'd0, locked}, (m_mode == 2) ? 32'd1 : 32'd0);
        check_eq("index", {29'd0, index}, m_index);
        check_eq("err", {31'd0, err}, {31'd0, m_err});
        check_eq("err_cnt", {{(32-ERR_W){1'b0}}, err_cnt}, m_errcnt);
`ifdef STD_CHK_FRAME_EN
        check_eq("frame_done", {31'd0, frame_done}, {31'd0, m_frame});
        if (m_frame) n_frames++;
`endif
    endtask

    // Drive one cycle's inputs, let the edge happen, then compare 1 time unit later.
    task automatic step(input logic v, input logic [2:0] c);
        seq_valid = v;
        seq_in    = c;
        @(posedge clk);
        model_step(v, c);
        #1;
        check_all();
    endtask

    task automatic send_pos(input int p);
        step(1'b1, seq_codes[p % 8]);
    endtask

    task automatic lock_up();
        for (int i = 0; i < 40 && m_mode != 2; i++) begin
            if (m_mode == 0) send_pos(0);
            else send_pos(m_exp);
        end
        check_eq("lock_up_reached", {31'd0, locked}, 32'd1);
    endtask

    // Global time limit; the test itself has no open-ended waits.
    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int g;
        int fr_before;
        rst       = 1'b0;
        seq_valid = 1'b0;
        seq_in    = 3'b000;
        n_frames  = 0;
        model_reset();

        // 1: reset, release, idle.
        repeat (2) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) step(1'b0, 3'b000);

        // 2: first four in-order codes lock on the 4th edge.
        send_pos(0); send_pos(1); send_pos(2);
        check_eq("t2_not_yet_locked", {31'd0, locked}, 32'd0);
        send_pos(3);
        check_eq("t2_locked", {31'd0, locked}, 32'd1);
        check_eq("t2_index", {29'd0, index}, 32'd3);

        // 3: skip a code once; single error, lock held.
        send_pos(4);
        send_pos(6);
        check_eq("t3_err", {31'd0, err}, 32'd1);
        check_eq("t3_err_cnt", {{(32-ERR_W){1'b0}}, err_cnt}, 32'd1);
        check_eq("t3_still_locked", {31'd0, locked}, 32'd1);
        step(1'b0, 3'b111);
        check_eq("t3_err_pulse_gone", {31'd0, err}, 32'd0);
        send_pos(m_exp);  // back in step with the flywheel
        send_pos(m_exp);

        // 4: two consecutive misses drop lock, then relock.
        send_pos(m_exp + 3);
        send_pos(m_exp + 3);
        check_eq("t4_unlocked", {31'd0, locked}, 32'd0);
        check_eq("t4_err_cnt", {{(32-ERR_W){1'b0}}, err_cnt}, 32'd3);
        for (int i = 0; i < 4; i++) send_pos(5 + i);
        check_eq("t4_relocked", {31'd0, locked}, 32'd1);

        // 5: mismatch during verify resyncs silently.
        send_pos(m_exp + 2);
        send_pos(m_exp + 2);  // second miss drops lock
        send_pos(0); send_pos(1); send_pos(5);
        check_eq("t5_no_err_verify", {31'd0, err}, 32'd0);
        send_pos(6); send_pos(7);
        check_eq("t5_not_locked", {31'd0, locked}, 32'd0);
        send_pos(0);
        check_eq("t5_locked", {31'd0, locked}, 32'd1);

        // Frame pulses across full locked cycles.
        fr_before = n_frames;
        for (int i = 0; i < 24; i++) send_pos(m_exp);
`ifdef STD_CHK_FRAME_EN
        check_eq("frames_counted", n_frames - fr_before, 3);
`endif

        // 6: 300 errors, alternating miss/hit so lock holds; counter saturates.
        for (int i = 0; i < 300; i++) begin
            send_pos(m_exp + 4);
            send_pos(m_exp);
        end
        check_eq("t6_saturated", {{(32-ERR_W){1'b0}}, err_cnt}, ERR_MAX);
        check_eq("t6_locked", {31'd0, locked}, 32'd1);

        // Async reset mid-stream, right after an error pulse.
        send_pos(m_exp + 1);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_eq("rst_locked", {31'd0, locked}, 32'd0);
        check_eq("rst_index", {29'd0, index}, 32'd0);
        check_eq("rst_err", {31'd0, err}, 32'd0);
        check_eq("rst_err_cnt", {{(32-ERR_W){1'b0}}, err_cnt}, 32'd0);
        check_eq("rst_frame", {31'd0, frame_done}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Random phase: mostly in-order stream with gaps, glitches and jumps.
        g = 0;
        for (int i = 0; i < 3000; i++) begin
            int r;
            logic v;
            logic [2:0] c;
            r = int'($urandom_range(0, 99));
            v = (r < 75);
            if (r < 6) c = 3'($urandom_range(0, 7));
            else c = seq_codes[g];
            if (r == 99) g = int'($urandom_range(0, 7));
            if (v) g = (g + 1) % 8;
            step(v, c);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
